// File: rtl/sram_access_arbiter.sv
// Arbitrates the single off-chip SRAM between the instruction fetch port (A, read-only)
// and the data port (B, read/write) with round-robin grants and fixed-length accesses.
module sram_access_arbiter #(
    parameter logic [31:0] BASE_ADDR     = 32'd1024,
    parameter int unsigned ACCESS_CYCLES = 5
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        a_req,
    input  logic [31:0] a_addr,
    output logic [31:0] a_rdata,
    output logic        a_ready,

    input  logic        b_req,
    input  logic        b_we,
    input  logic [31:0] b_addr,
    input  logic [31:0] b_wdata,
    output logic [31:0] b_rdata,
    output logic        b_ready,

    output logic        busy,
    output logic        sram_we_n,
    output logic [16:0] sram_address,
    inout  wire  [31:0] sram_dq
);

    localparam int unsigned       CW   = $clog2(ACCESS_CYCLES);
    localparam logic [CW-1:0]     LAST = CW'(ACCESS_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_e;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_e;

    state_e        state, state_next;
    logic [CW-1:0] counter;
    port_e         last_grant;
    port_e         cur_port;
    logic          cur_we;
    logic [31:0]   cur_wdata;

    logic          grant_valid;
    port_e         grant_port;
    logic [31:0]   grant_addr;
    logic          drive_dq;

    // NOTE: every combinational output gets a default before the case, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_next  = state;
        grant_valid = 1'b0;
        grant_port  = PORT_A;
        case (state)
            IDLE: begin
                if (a_req || b_req) begin
                    grant_valid = 1'b1;
                    if (a_req && b_req)
                        grant_port = (last_grant == PORT_A) ? PORT_B : PORT_A;
                    else
                        grant_port = b_req ? PORT_B : PORT_A;
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                if (counter == LAST)
                    state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign grant_addr = (grant_port == PORT_B) ? b_addr : a_addr;

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    // NOTE: the latched request and read-data registers are reset too, because the
    // read-data outputs must come out of reset as zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            counter      <= '0;
            last_grant   <= PORT_B;
            cur_port     <= PORT_A;
            cur_we       <= 1'b0;
            cur_wdata    <= '0;
            sram_address <= '0;
            a_rdata      <= '0;
            b_rdata      <= '0;
        end else if (grant_valid) begin
            counter      <= '0;
            last_grant   <= grant_port;
            cur_port     <= grant_port;
            cur_we       <= (grant_port == PORT_B) && b_we;
            cur_wdata    <= b_wdata;
            sram_address <= 17'((grant_addr - BASE_ADDR) >> 2);
        end else if (state == ACCESS) begin
            if (counter != LAST)
                counter <= counter + CW'(1);
            // Read data is taken from the bus on the edge that leaves the final cycle.
            if (counter == LAST && !cur_we) begin
                if (cur_port == PORT_B)
                    b_rdata <= sram_dq;
                else
                    a_rdata <= sram_dq;
            end
        end
    end

    // The write strobe rises one cycle before the bus is released, giving data hold.
    assign drive_dq  = (state == ACCESS) && cur_we;
    assign sram_we_n = !(drive_dq && (counter != LAST));
    assign sram_dq   = drive_dq ? cur_wdata : 'z;

    assign busy    = (state != IDLE);
    assign a_ready = (state == DONE) && (cur_port == PORT_A);
    assign b_ready = (state == DONE) && (cur_port == PORT_B);

endmodule
